// File: rtl/c_packer.sv
// Packs a stream of 16-bit (RVC) and 32-bit instructions halfword-tight into
// aligned 32-bit memory words, with a single-stage output register.
module c_packer #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter logic [15:0] NOP16     = 16'h0001
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_inst,
    output logic [31:0] inst_addr_o,
    input  logic        flush,
    output logic        idle_o,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_word,
    output logic [31:0] out_addr,
    output logic        out_straddle
);

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_HALF  = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [15:0] r_pend;
    logic [15:0] w_pend_next;
    logic [31:0] r_wr_addr;
    logic        r_out_valid;
    logic [31:0] r_out_word;
    logic [31:0] r_out_addr;
    logic        r_out_straddle;

    logic        w_ready;
    logic        w_accept;
    logic        w_is16;
    logic        w_flush_go;
    logic        w_emit;
    logic [31:0] w_emit_word;
    logic        w_emit_straddle;

    // No lookahead: the output slot is free or being drained this cycle.
    assign w_ready    = ~r_out_valid | out_ready;
    assign w_accept   = in_valid & w_ready;
    assign w_is16     = (in_inst[1:0] != 2'b11);
    assign w_flush_go = flush & ~in_valid & (r_state == S_HALF) & w_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_EMPTY;
            r_pend  <= 16'h0;
        end else begin
            r_state <= w_state_next;
            r_pend  <= w_pend_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_pend_next     = r_pend;
        w_emit          = 1'b0;
        w_emit_word     = 32'h0;
        w_emit_straddle = 1'b0;
        if (w_accept) begin
            if (r_state == S_EMPTY) begin
                if (w_is16) begin
                    w_pend_next  = in_inst[15:0];
                    w_state_next = S_HALF;
                end else begin
                    w_emit      = 1'b1;
                    w_emit_word = in_inst;
                end
            end else begin
                // Pending half fills the lower slot; the new low half completes the word.
                w_emit      = 1'b1;
                w_emit_word = {in_inst[15:0], r_pend};
                if (w_is16) begin
                    w_state_next = S_EMPTY;
                end else begin
                    w_emit_straddle = 1'b1;
                    w_pend_next     = in_inst[31:16];
                end
            end
        end else if (w_flush_go) begin
            w_emit       = 1'b1;
            w_emit_word  = {NOP16, r_pend};
            w_state_next = S_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_addr      <= BASE_ADDR;
            r_out_valid    <= 1'b0;
            r_out_word     <= 32'h0;
            r_out_addr     <= BASE_ADDR;
            r_out_straddle <= 1'b0;
        end else if (w_emit) begin
            r_out_valid    <= 1'b1;
            r_out_word     <= w_emit_word;
            r_out_addr     <= r_wr_addr;
            r_out_straddle <= w_emit_straddle;
            r_wr_addr      <= r_wr_addr + 32'd4;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign in_ready     = w_ready;
    assign inst_addr_o  = r_wr_addr + ((r_state == S_HALF) ? 32'd2 : 32'd0);
    assign idle_o       = (r_state == S_EMPTY) & ~r_out_valid;
    assign out_valid    = r_out_valid;
    assign out_word     = r_out_word;
    assign out_addr     = r_out_addr;
    assign out_straddle = r_out_straddle;

endmodule

// File: tb/tb_c_packer.sv
// Bench for c_packer: directed scenarios plus random traffic, checked against
// a halfword-stream reference model of the packed memory image.
module tb_c_packer;

    localparam logic [31:0] BASE  = 32'h0000_0000;
    localparam logic [31:0] WBASE = 32'hFFFF_FFFC;
    localparam logic [15:0] NOP   = 16'h0001;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_inst;
    logic [31:0] inst_addr_o;
    logic        flush;
    logic        idle_o;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_word;
    logic [31:0] out_addr;
    logic        out_straddle;

    logic        w_in_valid;
    logic        w_in_ready;
    logic [31:0] w_in_inst;
    logic [31:0] w_inst_addr;
    logic        w_idle;
    logic        w_out_valid;
    logic [31:0] w_out_word;
    logic [31:0] w_out_addr;
    logic        w_out_straddle;

    always #5 clk = ~clk;

    c_packer #(.BASE_ADDR(BASE), .NOP16(NOP)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst),
        .inst_addr_o(inst_addr_o), .flush(flush), .idle_o(idle_o),
        .out_valid(out_valid), .out_ready(out_ready), .out_word(out_word),
        .out_addr(out_addr), .out_straddle(out_straddle)
    );

    c_packer #(.BASE_ADDR(WBASE), .NOP16(NOP)) dut_wrap (
        .clk(clk), .reset(reset),
        .in_valid(w_in_valid), .in_ready(w_in_ready), .in_inst(w_in_inst),
        .inst_addr_o(w_inst_addr), .flush(1'b0), .idle_o(w_idle),
        .out_valid(w_out_valid), .out_ready(1'b1), .out_word(w_out_word),
        .out_addr(w_out_addr), .out_straddle(w_out_straddle)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: memory is a linear sequence of halfwords; every second
    // halfword completes a word whose address follows from the halfword count.
    logic [31:0] hw_total;
    logic [15:0] m_pend;
    logic        m_emitted;
    logic [31:0] m_emit_word;
    logic [31:0] m_emit_addr;
    logic        m_emit_str;
    logic        exp_ov;
    logic [31:0] exp_word;
    logic [31:0] exp_addr;
    logic        exp_str;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        hw_total = 32'd0;
        m_pend   = 16'h0;
        exp_ov   = 1'b0;
        exp_word = 32'h0;
        exp_addr = BASE;
        exp_str  = 1'b0;
    endtask

    // is_low32 marks the low half of a 32-bit instruction.
    task automatic push_hw(input logic [15:0] h, input logic is_low32);
        if (hw_total[0] == 1'b0) begin
            m_pend = h;
        end else begin
            m_emitted   = 1'b1;
            m_emit_word = {h, m_pend};
            m_emit_addr = BASE + 2 * (hw_total - 32'd1);
            m_emit_str  = is_low32;
        end
        hw_total = hw_total + 32'd1;
    endtask

    task automatic check_outputs();
        chk("out_valid", {31'b0, out_valid}, {31'b0, exp_ov});
        if (exp_ov) begin
            chk("out_word", out_word, exp_word);
            chk("out_addr", out_addr, exp_addr);
            chk("out_straddle", {31'b0, out_straddle}, {31'b0, exp_str});
        end
    endtask

    // One clock cycle; entered and left 1 time unit after a rising edge.
    task automatic step(input logic v, input logic [31:0] inst, input logic fl, input logic ordy);
        logic exp_ready, acc, fgo;
        in_valid  = v;
        in_inst   = inst;
        flush     = fl;
        out_ready = ordy;
        @(negedge clk);
        exp_ready = ~exp_ov | ordy;
        check_outputs();
        chk("in_ready", {31'b0, in_ready}, {31'b0, exp_ready});
        chk("idle_o", {31'b0, idle_o}, {31'b0, (~hw_total[0]) & ~exp_ov});
        if (v) chk("inst_addr_o", inst_addr_o, BASE + 2 * hw_total);
        acc = v & exp_ready;
        fgo = fl & ~v & hw_total[0] & exp_ready;
        @(posedge clk);
        m_emitted = 1'b0;
        if (acc) begin
            if (inst[1:0] != 2'b11) begin
                push_hw(inst[15:0], 1'b0);
            end else begin
                push_hw(inst[15:0], 1'b1);
                push_hw(inst[31:16], 1'b0);
            end
        end else if (fgo) begin
            push_hw(NOP, 1'b0);
        end
        if (m_emitted) begin
            exp_ov   = 1'b1;
            exp_word = m_emit_word;
            exp_addr = m_emit_addr;
            exp_str  = m_emit_str;
        end else if (ordy) begin
            exp_ov = 1'b0;
        end
        #1;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        in_valid = 1'b0;
        flush    = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        @(negedge clk);
        chk("rst out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst out_word", out_word, 32'h0);
        chk("rst out_addr", out_addr, BASE);
        chk("rst out_straddle", {31'b0, out_straddle}, 32'd0);
        chk("rst in_ready", {31'b0, in_ready}, 32'd1);
        chk("rst idle_o", {31'b0, idle_o}, 32'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] r;
        reset      = 1'b1;
        in_valid   = 1'b0;
        in_inst    = 32'h0;
        flush      = 1'b0;
        out_ready  = 1'b1;
        w_in_valid = 1'b0;
        w_in_inst  = 32'h0;
        model_reset();
        do_reset();

        // Idle with no stimulus.
        step(1'b0, 32'h0, 1'b0, 1'b1);
        step(1'b0, 32'h0, 1'b0, 1'b1);

        // Two compressed instructions form one word.
        step(1'b1, 32'h0000_4501, 1'b0, 1'b1);
        step(1'b1, 32'h0000_0505, 1'b0, 1'b1);
        step(1'b0, 32'h0, 1'b0, 1'b1);
        step(1'b0, 32'h0, 1'b0, 1'b1);

        // Straddling 32-bit instruction.
        do_reset();
        step(1'b1, 32'h0000_4501, 1'b0, 1'b1);
        step(1'b1, 32'h00A0_0093, 1'b0, 1'b1);
        step(1'b1, 32'h0000_0505, 1'b0, 1'b1);
        step(1'b0, 32'h0, 1'b0, 1'b1);
        step(1'b0, 32'h0, 1'b0, 1'b1);

        // Backpressure holds the output word and stalls input.
        do_reset();
        step(1'b1, 32'h0000_0013, 1'b0, 1'b1);
        repeat (3) step(1'b1, 32'h0010_0093, 1'b0, 1'b0);
        step(1'b1, 32'h0010_0093, 1'b0, 1'b1);
        step(1'b0, 32'h0, 1'b0, 1'b1);
        step(1'b0, 32'h0, 1'b0, 1'b1);

        // Flush pads a pending half; flush in EMPTY is ignored; input beats flush.
        do_reset();
        step(1'b1, 32'h0000_4501, 1'b0, 1'b1);
        step(1'b0, 32'h0, 1'b1, 1'b1);
        step(1'b0, 32'h0, 1'b1, 1'b1);
        step(1'b0, 32'h0, 1'b1, 1'b1);
        step(1'b1, 32'hFFFF_4501, 1'b0, 1'b1);
        step(1'b1, 32'h1234_0505, 1'b1, 1'b1);
        step(1'b0, 32'h0, 1'b1, 1'b1);
        step(1'b0, 32'h0, 1'b0, 1'b1);

        // Reset while HALF at wr_addr 8 discards the pending half.
        do_reset();
        step(1'b1, 32'h0000_0013, 1'b0, 1'b1);
        step(1'b1, 32'h0000_0093, 1'b0, 1'b1);
        step(1'b1, 32'h0000_4501, 1'b0, 1'b1);
        chk("pre-reset inst_addr", inst_addr_o, 32'd10);
        do_reset();
        step(1'b1, 32'h0040_0113, 1'b0, 1'b1);
        step(1'b0, 32'h0, 1'b0, 1'b1);

        // Random mix of widths, flushes and backpressure.
        for (int i = 0; i < 400; i++) begin
            r = $urandom;
            if ($urandom_range(0, 1) == 1) r[1:0] = 2'b11;
            else if (r[1:0] == 2'b11) r[1:0] = 2'b01;
            step($urandom_range(0, 3) != 0, r, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 3) != 0);
        end
        step(1'b0, 32'h0, 1'b1, 1'b1);
        step(1'b0, 32'h0, 1'b0, 1'b1);
        step(1'b0, 32'h0, 1'b0, 1'b1);

        // Address wrap on the second instance.
        chk("wrap inst_addr", w_inst_addr, WBASE);
        w_in_valid = 1'b1;
        w_in_inst  = 32'h0000_0013;
        @(posedge clk);
        #1;
        w_in_inst = 32'h0000_0093;
        @(negedge clk);
        chk("wrap out_addr0", w_out_addr, WBASE);
        chk("wrap out_word0", w_out_word, 32'h0000_0013);
        chk("wrap in_ready", {31'b0, w_in_ready}, 32'd1);
        @(posedge clk);
        #1;
        w_in_valid = 1'b0;
        @(negedge clk);
        chk("wrap out_valid1", {31'b0, w_out_valid}, 32'd1);
        chk("wrap out_addr1", w_out_addr, 32'h0000_0000);
        chk("wrap out_word1", w_out_word, 32'h0000_0093);
        chk("wrap straddle1", {31'b0, w_out_straddle}, 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("wrap idle", {31'b0, w_idle}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/c_packer.md
Name: c_packer

Overview:
- Instruction-stream packer for the compressed (RVC) extension, on the write side of instruction memory.
- Accepts a stream of instructions, each either 16-bit compressed or 32-bit, and packs them halfword-tight into aligned 32-bit memory words.
- A 32-bit instruction that follows an odd number of halfwords straddles a word boundary. Its low half goes in the upper 16 bits of one word and its high half in the lower 16 bits of the next word. This is exactly the misaligned layout the fetch-side realigner reassembles.
- Used by the program loader/self-test path and as a golden stimulus generator for fetch verification.

Parameters:
- BASE_ADDR, 32'h0000_0000, byte address of the first packed word; must be 4-byte aligned.
- NOP16, 16'h0001, halfword (c.nop) used to pad a pending half on flush.

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- in_valid  in  1  instruction present
- in_ready  out  1  instruction accepted this cycle when in_valid & in_ready
- in_inst  in  32  instruction; in_inst[1:0]!=2'b11 means 16-bit in in_inst[15:0] (upper bits ignored); otherwise 32-bit
- inst_addr_o  out  32  byte address at which the current in_inst will be placed (combinational)
- flush  in  1  level request: pad and emit any pending halfword
- idle_o  out  1  no pending halfword and no word held in the output register
- out_valid  out  1  packed word available
- out_ready  in  1  consumer accepts word when out_valid & out_ready
- out_word  out  32  packed word, little-endian halfword order ([15:0] = lower address)
- out_addr  out  32  byte address of out_word
- out_straddle  out  1  out_word[31:16] holds the low half of a 32-bit instruction continued in the next word

Behaviour:
- Reset values:
  - state=EMPTY, pend=16'h0, wr_addr=BASE_ADDR.
  - out_valid=0, out_word=0, out_addr=BASE_ADDR, out_straddle=0.
  - in_ready=1, idle_o=1.
- Reset mid-operation discards the pending halfword and any held output word. No pad word is emitted.
- Output register: single stage.
  - out_word, out_addr and out_straddle hold stable while out_valid & ~out_ready.
  - out_valid clears on acceptance unless a new word is loaded in the same cycle.
- Ready rule: in_ready = ~out_valid | out_ready. This is identical for 16-bit and 32-bit inputs, with no lookahead.
- accept = in_valid & in_ready. "Emit W" means load the output register with W, set out_addr=wr_addr, then wr_addr += 4 (modulo 2^32, wraps silently).
- Accepted-input transitions (state EMPTY / HALF, pend = held halfword):
  - EMPTY + 16b: pend<=in_inst[15:0]; go to HALF; nothing emitted.
  - EMPTY + 32b: emit in_inst, straddle=0; stay EMPTY.
  - HALF + 16b: emit {in_inst[15:0], pend}, straddle=0; go to EMPTY.
  - HALF + 32b: emit {in_inst[15:0], pend}, straddle=1; pend<=in_inst[31:16]; stay HALF.
- Flush:
  - Acts only when flush=1, in_valid=0, state=HALF and in_ready=1.
  - Emits {NOP16, pend}, straddle=0, and goes to EMPTY.
  - If in_valid=1, the input takes priority and flush waits.
  - Flush in EMPTY has no effect.
- inst_addr_o = wr_addr + (state==HALF ? 2 : 0). Valid whenever in_valid; does not depend on out_ready.
- idle_o = (state==EMPTY) & ~out_valid.
- Latency: a word appears on out_valid the cycle after the accept that completes it.
- Throughput: one input per cycle with out_ready held high.

Test Plan:
- Reset, then idle with no stimulus -> in_ready=1, idle_o=1, out_valid=0, out_addr=0, out_word=0.
- BASE_ADDR=0; 16b 0x4501 then 16b 0x0505 back-to-back -> one word 0x0505_4501 at out_addr 0, straddle=0; inst_addr_o 0 then 2.
- Straddle: 16b 0x4501, then 32b 0x00A0_0093, then 16b 0x0505:
  - word 0x0093_4501 at addr 0, straddle=1;
  - then word 0x0505_00A0 at addr 4, straddle=0;
  - inst_addr_o 0, 2, 6; idle_o=1 at end.
- Backpressure: emit 32b 0x0000_0013 with out_ready=0 for 3 cycles and the next 32b presented -> in_ready=0; out_word stays 0x0000_0013 at addr 0; next input accepted only after out_ready=1.
- Flush: HALF with pend 0x4501, flush=1, in_valid=0 -> word 0x0001_4501, straddle=0. Flush asserted in EMPTY -> no output. flush with in_valid=1 -> input processed first.
- Reset mid-HALF (pend 0x4501, wr_addr=8) -> no pad word; out_valid=0, out_addr=BASE_ADDR. Next 32b lands at addr BASE_ADDR. Plus wrap test: BASE_ADDR=32'hFFFF_FFFC, two 32b inputs -> out_addr 0xFFFF_FFFC then 0x0000_0000.
